reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
//  Parametrised reset generator and sequencer for one clock domain. Merges a synchronous
//  system reset, NSRC asynchronous reset-request levels and a software reset pulse.
//  Drives NOUT active-high output resets: all assert together, are held for a minimum
//  time, then release in index order with a fixed stagger. Records which sources
//  caused the last reset(s). Sits at the top of each clock domain, feeding subsystem resets.
// PARAMETERS
//  NSRC           2   number of asynchronous reset-request inputs (>=1)
//  NOUT           4   number of sequenced output resets (>=1)
//  SYNC_STAGES    2   synchroniser flops per SRC_REQ bit (>=2)
//  HOLD_CYCLES    16  consecutive request-free cycles before OUT_RST[0] releases (>=1)
//  STAGGER_CYCLES 4   extra cycles between successive channel releases (>=0)
// PORTS
//  CLK        in   1       domain clock; all state updates on posedge
//  RST        in   1       synchronous, active-high reset
//  SRC_REQ    in   NSRC    async reset requests, active-high level, any width >= 1 CLK
//  SW_RST     in   1       synchronous single-cycle software reset pulse
//  CAUSE_CLR  in   1       synchronous pulse; clears RST_CAUSE
//  OUT_RST    out  NOUT    sequenced resets, active-high
//  RST_DONE   out  1       high once every OUT_RST bit is released
//  RST_CAUSE  out  NSRC+2  sticky causes: [0]=RST, [NSRC:1]=SRC_REQ, [NSRC+1]=SW_RST
// BEHAVIOUR
//  - Reset (RST=1): sync chains<=0, state<=HOLD, cnt<=0, idx<=0, OUT_RST<=all 1,
//    RST_DONE<=0, RST_CAUSE<=bit0 set plus any other cause asserted that cycle.
//  - req = |src_sync | SW_RST; src_sync = last flop of each sync chain.
//    Latency: SRC_REQ to OUT_RST = SYNC_STAGES+1 edges; SW_RST to OUT_RST = 1 edge.
//  - States: HOLD, RELEASE, RUN. req=1 in ANY state (including mid-release):
//    state<=HOLD, cnt<=0, idx<=0, OUT_RST<=all 1, RST_DONE<=0. Already-released
//    channels re-assert.
//  - HOLD, req=0: if cnt==HOLD_CYCLES-1, OUT_RST[0]<=0, cnt<=0, idx<=1,
//    state<=RELEASE (RUN with RST_DONE<=1 if NOUT==1); else cnt<=cnt+1.
//    A req=1 edge restarts the count from 0; the hold is consecutive cycles.
//  - RELEASE: if cnt==STAGGER_CYCLES, OUT_RST[idx]<=0, cnt<=0, idx<=idx+1; when
//    idx==NOUT-1, state<=RUN and RST_DONE<=1 on the same edge. Else cnt<=cnt+1.
//  - Timing: OUT_RST[i] falls on the (HOLD_CYCLES + i*(STAGGER_CYCLES+1))-th edge
//    after the first req=0 edge in HOLD. RST_DONE rises with OUT_RST[NOUT-1].
//  - RUN: outputs stable until req.
//  - OUT_RST release order is monotonic: OUT_RST[j]==0 implies OUT_RST[i]==0 for i<j.
//  - RST_CAUSE: each bit sets on any edge where its source is active (src_sync bit,
//    SW_RST, RST). CAUSE_CLR clears all bits. Set wins over CAUSE_CLR on the same edge.
//  - Widths: cnt is CNT_W = $clog2(max(HOLD_CYCLES, STAGGER_CYCLES+1)+1) bits.
//    idx is $clog2(NOUT)+1 bits. Counters never wrap; they reset on each match.
//  - All outputs registered. No combinational path from inputs to outputs.
// STRUCTURE
//  - Package reset_seq_pkg: state enum typedef (HOLD/RELEASE/RUN) and cause-bit index
//    constants (CAUSE_RST=0, CAUSE_SRC_BASE=1); CAUSE_SW is derived locally as NSRC+1.
//  - Sub-module reset_req_sync: SYNC_STAGES-deep 1-bit synchroniser, flops marked
//    ASYNC_REG, cleared by RST. One instance is generated per SRC_REQ bit.
//  - Top level holds the FSM, counters, output register and cause register.
// TESTING (defaults unless noted)
//  1. RST=1 3 cycles, then 0 -> OUT_RST=4'hF, RST_DONE=0, RST_CAUSE=4'b0001. OUT_RST[0..3]
//     fall on edges 16, 21, 26, 31 after RST low. RST_DONE=1 on edge 31.
//  2. In RUN, SW_RST pulse 1 cycle -> OUT_RST=4'hF next edge, RST_CAUSE[3]=1, re-sequence
//     with the same 16/21/26/31 spacing.
//  3. In RUN, SRC_REQ[1] high 5 cycles -> OUT_RST=4'hF 3 edges after assertion, held until
//     16 edges after src_sync falls. RST_CAUSE[2]=1.
//  4. SW_RST during RELEASE after OUT_RST[1] fell -> all 4 bits re-assert next edge. Full
//     hold restarts. Check monotonic release order holds every cycle.
//  5. CAUSE_CLR and SW_RST on the same edge -> RST_CAUSE=4'b1000. CAUSE_CLR alone -> 0.
//  6. NOUT=1, HOLD_CYCLES=1, STAGGER_CYCLES=0 -> OUT_RST and RST_DONE toggle on the first
//     req-free edge. NOUT=3, STAGGER_CYCLES=0 -> releases on consecutive edges.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types and cause-bit positions for the reset sequencer and its testbench.
package reset_seq_pkg;

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2
   } state_t;

   localparam int CAUSE_RST      = 0;
   localparam int CAUSE_SRC_BASE = 1;

endpackage

// File: rtl/reset_req_sync.sv
// One-bit level synchroniser for an asynchronous reset request, cleared by the domain reset.
module reset_req_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_req,
   output logic o_sync
);

   (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] r_chain;

   // NOTE: the chain is cleared synchronously so a stale request cannot survive a domain reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_chain <= '0;
      end else begin
         r_chain <= {r_chain[SYNC_STAGES-2:0], i_req};
      end
   end

   assign o_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Merges system, asynchronous and software reset requests; holds then releases NOUT
// output resets in index order and records the causes of the last reset(s).
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int NSRC           = 2,
   parameter int NOUT           = 4,
   parameter int SYNC_STAGES    = 2,
   parameter int HOLD_CYCLES    = 16,
   parameter int STAGGER_CYCLES = 4
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic [NSRC-1:0] i_src_req,
   input  logic            i_sw_rst,
   input  logic            i_cause_clr,
   output logic [NOUT-1:0] o_out_rst,
   output logic            o_rst_done,
   output logic [NSRC+1:0] o_rst_cause
);

   localparam int CAUSE_SW = NSRC + 1;
   localparam int CNT_MAX  = (HOLD_CYCLES > STAGGER_CYCLES + 1) ? HOLD_CYCLES : STAGGER_CYCLES + 1;
   localparam int CNT_W    = $clog2(CNT_MAX + 1);
   localparam int IDX_W    = $clog2(NOUT) + 1;

   logic [NSRC-1:0] w_src_sync;
   logic            w_req;
   logic [NSRC+1:0] w_cause_set;

   state_t          r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [IDX_W-1:0] r_idx;
   logic [NOUT-1:0] r_out_rst;
   logic            r_rst_done;
   logic [NSRC+1:0] r_rst_cause;

   for (genvar g = 0; g < NSRC; g++) begin : g_sync
      reset_req_sync #(
         .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
         .i_clk  (i_clk),
         .i_rst  (i_rst),
         .i_req  (i_src_req[g]),
         .o_sync (w_src_sync[g])
      );
   end

   assign w_req = (|w_src_sync) | i_sw_rst;

   // NOTE: default first so every bit of the combinational vector is always assigned (no latch).
   always_comb begin
      w_cause_set                            = '0;
      w_cause_set[CAUSE_RST]                 = i_rst;
      w_cause_set[CAUSE_SRC_BASE +: NSRC]    = w_src_sync;
      w_cause_set[CAUSE_SW]                  = i_sw_rst;
   end

   // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= ST_HOLD;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_out_rst   <= '1;
         r_rst_done  <= 1'b0;
         r_rst_cause <= w_cause_set;
      end else begin
         // Any set wins over a simultaneous clear.
         r_rst_cause <= (i_cause_clr ? '0 : r_rst_cause) | w_cause_set;

         if (w_req) begin
            r_state    <= ST_HOLD;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_out_rst  <= '1;
            r_rst_done <= 1'b0;
         end else begin
            case (r_state)
               ST_HOLD: begin
                  if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                     r_out_rst[0] <= 1'b0;
                     r_cnt        <= '0;
                     r_idx        <= IDX_W'(1);
                     if (NOUT == 1) begin
                        r_state    <= ST_RUN;
                        r_rst_done <= 1'b1;
                     end else begin
                        r_state <= ST_RELEASE;
                     end
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
               ST_RELEASE: begin
                  if (r_cnt == CNT_W'(STAGGER_CYCLES)) begin
                     r_out_rst <= r_out_rst & ~(NOUT'(1) << r_idx);
                     r_cnt     <= '0;
                     r_idx     <= r_idx + IDX_W'(1);
                     if (r_idx == IDX_W'(NOUT - 1)) begin
                        r_state    <= ST_RUN;
                        r_rst_done <= 1'b1;
                     end
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
               ST_RUN: begin
                  r_state <= ST_RUN;
               end
               default: begin
                  r_state <= ST_HOLD;
               end
            endcase
         end
      end
   end

   assign o_out_rst   = r_out_rst;
   assign o_rst_done  = r_rst_done;
   assign o_rst_cause = r_rst_cause;

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomised and directed bench for reset_sequencer, checked against a quiet-time model.
module tb_reset_sequencer;

   logic       clk;
   logic       rst;
   logic [1:0] src;
   logic       sw;
   logic       clr;

   logic [3:0] out4;
   logic       done4;
   logic [3:0] cause4;
   logic [0:0] out1;
   logic       done1;
   logic [2:0] cause1;
   logic [2:0] out3;
   logic       done3;
   logic [3:0] cause3;

   int n_vec;
   int n_err;

   // Model state per instance: req-free edge count, cause bits, request delay line.
   int          q4, q1, q3;
   logic [7:0]  c4, c1, c3;
   logic [63:0] d4, d1, d3;

   reset_sequencer #(
      .NSRC(2), .NOUT(4), .SYNC_STAGES(2), .HOLD_CYCLES(16), .STAGGER_CYCLES(4)
   ) u_dut4 (
      .i_clk(clk), .i_rst(rst), .i_src_req(src), .i_sw_rst(sw), .i_cause_clr(clr),
      .o_out_rst(out4), .o_rst_done(done4), .o_rst_cause(cause4)
   );

   reset_sequencer #(
      .NSRC(1), .NOUT(1), .SYNC_STAGES(2), .HOLD_CYCLES(1), .STAGGER_CYCLES(0)
   ) u_dut1 (
      .i_clk(clk), .i_rst(rst), .i_src_req(src[0:0]), .i_sw_rst(sw), .i_cause_clr(clr),
      .o_out_rst(out1), .o_rst_done(done1), .o_rst_cause(cause1)
   );

   reset_sequencer #(
      .NSRC(2), .NOUT(3), .SYNC_STAGES(3), .HOLD_CYCLES(5), .STAGGER_CYCLES(0)
   ) u_dut3 (
      .i_clk(clk), .i_rst(rst), .i_src_req(src), .i_sw_rst(sw), .i_cause_clr(clr),
      .o_out_rst(out3), .o_rst_done(done3), .o_rst_cause(cause3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance one edge: src_sync is the request sampled s edges earlier (zero after reset).
   function automatic void mdl_step(input int s, input int nsrc, input logic r,
                                    input logic [7:0] req_in, input logic sw_in, input logic clr_in,
                                    inout int quiet, inout logic [7:0] cause, inout logic [63:0] dly);
      logic [7:0] mask;
      logic [7:0] sync_now;
      logic [7:0] set;
      mask     = 8'((1 << nsrc) - 1);
      sync_now = dly[(s-1)*8 +: 8] & mask;
      set      = {7'd0, r} | (sync_now << 1) | (8'(sw_in) << (nsrc + 1));
      if (r) begin
         quiet = 0;
         cause = set;
         dly   = '0;
      end else begin
         if ((|sync_now) || sw_in) quiet = 0;
         else if (quiet < 100000) quiet++;
         cause = (clr_in ? 8'd0 : cause) | set;
         dly   = {dly[55:0], req_in & mask};
      end
   endfunction

   // Channel i is held until HOLD + i*(STAGGER+1) consecutive req-free edges have passed.
   function automatic logic [7:0] exp_out(input int quiet, input int nout, input int hold, input int stag);
      logic [7:0] v;
      v = '0;
      for (int i = 0; i < nout; i++) v[i] = (quiet < hold + i * (stag + 1));
      return v;
   endfunction

   function automatic logic exp_done(input int quiet, input int nout, input int hold, input int stag);
      return quiet >= hold + (nout - 1) * (stag + 1);
   endfunction

   function automatic logic is_mono(input logic [7:0] v, input int n);
      for (int i = 1; i < n; i++) if (v[i-1] && !v[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic tick();
      mdl_step(2, 2, rst, {6'd0, src}, sw, clr, q4, c4, d4);
      mdl_step(2, 1, rst, {6'd0, src}, sw, clr, q1, c1, d1);
      mdl_step(3, 2, rst, {6'd0, src}, sw, clr, q3, c3, d3);
      @(negedge clk);
      check("d4.out",   32'(out4),   32'(exp_out(q4, 4, 16, 4)));
      check("d4.done",  32'(done4),  32'(exp_done(q4, 4, 16, 4)));
      check("d4.cause", 32'(cause4), 32'(c4[3:0]));
      check("d4.mono",  32'(is_mono({4'd0, out4}, 4)), 32'd1);
      check("d1.out",   32'(out1),   32'(exp_out(q1, 1, 1, 0)));
      check("d1.done",  32'(done1),  32'(exp_done(q1, 1, 1, 0)));
      check("d1.cause", 32'(cause1), 32'(c1[2:0]));
      check("d3.out",   32'(out3),   32'(exp_out(q3, 3, 5, 0)));
      check("d3.done",  32'(done3),  32'(exp_done(q3, 3, 5, 0)));
      check("d3.cause", 32'(cause3), 32'(c3[3:0]));
      check("d3.mono",  32'(is_mono({5'd0, out3}, 3)), 32'd1);
   endtask

   task automatic drive(input logic r, input logic [1:0] s, input logic w, input logic c);
      rst = r;
      src = s;
      sw  = w;
      clr = c;
      tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 2'b00, 1'b0, 1'b0);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      q4 = 0; q1 = 0; q3 = 0;
      c4 = '0; c1 = '0; c3 = '0;
      d4 = '0; d1 = '0; d3 = '0;

      // Power-on reset, then a full release sequence.
      for (int i = 0; i < 3; i++) drive(1'b1, 2'b00, 1'b0, 1'b0);
      check("por.out",   32'(out4),   32'hF);
      check("por.cause", 32'(cause4), 32'h1);
      idle(40);
      check("run.done",  32'(done4),  32'd1);

      // Software reset from RUN.
      drive(1'b0, 2'b00, 1'b1, 1'b0);
      check("sw.out", 32'(out4), 32'hF);
      idle(40);

      // Asynchronous request on bit 1 for five cycles.
      for (int i = 0; i < 5; i++) drive(1'b0, 2'b10, 1'b0, 1'b0);
      idle(40);

      // Software reset mid-release, after channel 1 has dropped.
      drive(1'b0, 2'b00, 1'b1, 1'b0);
      idle(22);
      check("mid.out", 32'(out4), 32'hC);
      drive(1'b0, 2'b00, 1'b1, 1'b0);
      check("mid.rearm", 32'(out4), 32'hF);
      idle(40);

      // Clear racing a software reset, then clear alone.
      drive(1'b0, 2'b00, 1'b1, 1'b1);
      check("clr.set_wins", 32'(cause4), 32'h8);
      idle(3);
      drive(1'b0, 2'b00, 1'b0, 1'b1);
      check("clr.alone", 32'(cause4), 32'h0);
      idle(40);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 299) == 0),
               {($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 2)},
               ($urandom_range(0, 59) == 0),
               ($urandom_range(0, 39) == 0));
      end
      idle(40);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
